pkt_len_filter: RTL and testbench

- Store-and-forward stage directly downstream of the user-data-path pattern-match pipeline stage, upstream of output queues.
- Buffers each packet, counts its 64-bit words, and forwards only packets whose length is within [min_words, max_words].
- Out-of-range packets are dropped by pointer rollback.
- Pass and drop totals are exposed for hardware registers in the parent.

---
 rtl/pkt_len_filter.sv | 235 +++++++++++++++++++++++
 tb/tb_pkt_len_filter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_len_filter.sv
// rtl/pkt_len_filter.sv - store-and-forward packet length filter with pass/drop counters
module pkt_len_filter #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH/8,
   parameter int ADDR_WIDTH = 9,
   parameter int LEN_WIDTH  = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   input  logic [LEN_WIDTH-1:0]  min_words,
   input  logic [LEN_WIDTH-1:0]  max_words,
   input  logic                  counter_clear,
   output logic [31:0]           pass_count,
   output logic [31:0]           drop_count
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int WORD_WIDTH = CTRL_WIDTH + DATA_WIDTH;
   // One slot is always kept empty so full and empty are distinguishable.
   localparam logic [ADDR_WIDTH-1:0] LAST_SLOT  = ADDR_WIDTH'(DEPTH - 1);
   // A non-EOP word arriving at this fill leaves no room for an EOP word.
   localparam logic [ADDR_WIDTH-1:0] ABORT_FILL = ADDR_WIDTH'(DEPTH - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      BODY = 2'd2,
      DROP = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [WORD_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] commit_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] free;
   logic [ADDR_WIDTH-1:0] uncommitted;

   logic [LEN_WIDTH-1:0]  len;
   logic [LEN_WIDTH-1:0]  new_len;
   logic [LEN_WIDTH-1:0]  pkt_min;
   logic [LEN_WIDTH-1:0]  pkt_max;
   logic                  seen_body;

   logic                  accept;
   logic                  ctrl_nz;
   logic                  over_max;
   logic                  at_limit;
   logic                  len_ok;
   logic                  eop_word;
   logic                  abort_word;
   logic                  rd_en;

   // per-word actions decoded from the FSM
   logic                  mem_we;
   logic                  wr_adv;
   logic                  do_commit;
   logic                  do_rollback;
   logic                  cfg_latch;
   logic                  len_inc;
   logic                  seen_load;
   logic                  seen_val;
   logic                  inc_pass;
   logic                  inc_drop;

   assign free        = LAST_SLOT - (wr_ptr - rd_ptr);
   assign uncommitted = wr_ptr - commit_ptr;
   // DROP discards words, so it never needs buffer space.
   assign in_rdy      = !reset && ((state == DROP) || (free != '0));
   assign accept      = in_wr && in_rdy;
   assign ctrl_nz     = |in_ctrl;
   assign new_len     = len + LEN_WIDTH'(1);
   assign over_max    = (pkt_max != '0) && (new_len > pkt_max);
   assign at_limit    = (uncommitted == ABORT_FILL);
   assign len_ok      = (new_len >= pkt_min) && ((pkt_max == '0) || (new_len <= pkt_max));
   assign eop_word    = (state == BODY) && ctrl_nz;
   assign abort_word  = ((state == HDR) || (state == BODY)) && !eop_word && (over_max || at_limit);
   assign rd_en       = out_rdy && (commit_ptr != rd_ptr);

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // next-state decode, advanced only by accepted words
   always_comb begin
      state_next = state;
      if (accept) begin
         case (state)
            IDLE: if (ctrl_nz) state_next = HDR;
            HDR, BODY: begin
               if (eop_word)        state_next = IDLE;
               else if (abort_word) state_next = DROP;
               else if (!ctrl_nz)   state_next = BODY;
            end
            DROP: if (ctrl_nz && seen_body) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // per-word action decode
   always_comb begin
      mem_we      = 1'b0;
      wr_adv      = 1'b0;
      do_commit   = 1'b0;
      do_rollback = 1'b0;
      cfg_latch   = 1'b0;
      len_inc     = 1'b0;
      seen_load   = 1'b0;
      seen_val    = 1'b0;
      inc_pass    = 1'b0;
      inc_drop    = 1'b0;
      if (accept) begin
         case (state)
            IDLE: begin
               if (ctrl_nz) begin
                  mem_we    = 1'b1;
                  wr_adv    = 1'b1;
                  cfg_latch = 1'b1;
               end
            end
            HDR, BODY: begin
               if (eop_word) begin
                  if (len_ok) begin
                     mem_we    = 1'b1;
                     wr_adv    = 1'b1;
                     do_commit = 1'b1;
                     inc_pass  = 1'b1;
                  end else begin
                     do_rollback = 1'b1;
                     inc_drop    = 1'b1;
                  end
               end else if (abort_word) begin
                  do_rollback = 1'b1;
                  seen_load   = 1'b1;
                  seen_val    = !ctrl_nz;
               end else begin
                  mem_we  = 1'b1;
                  wr_adv  = 1'b1;
                  len_inc = 1'b1;
               end
            end
            DROP: begin
               if (!ctrl_nz) begin
                  seen_load = 1'b1;
                  seen_val  = 1'b1;
               end else if (seen_body) begin
                  inc_drop  = 1'b1;
                  seen_load = 1'b1;
                  seen_val  = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // packet buffer write port; contents are only meaningful behind the pointers
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr] <= {in_ctrl, in_data};
   end

   // write, commit and read pointers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
      end else begin
         if (do_rollback)  wr_ptr <= commit_ptr;
         else if (wr_adv)  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (do_commit)    commit_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (rd_en)        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
   end

   // packet-local length, limits snapshot and body-seen flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len       <= '0;
         pkt_min   <= '0;
         pkt_max   <= '0;
         seen_body <= 1'b0;
      end else begin
         if (cfg_latch) begin
            len     <= LEN_WIDTH'(1);
            pkt_min <= min_words;
            pkt_max <= max_words;
         end else if (len_inc) begin
            len <= new_len;
         end
         if (seen_load) seen_body <= seen_val;
      end
   end

   // registered read port: word read in one cycle is strobed out the next
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_wr   <= 1'b0;
         out_data <= '0;
         out_ctrl <= '0;
      end else begin
         out_wr <= rd_en;
         if (rd_en) {out_ctrl, out_data} <= mem[rd_ptr];
      end
   end

   // pass/drop totals; clear wins over a same-cycle increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pass_count <= '0;
         drop_count <= '0;
      end else if (counter_clear) begin
         pass_count <= '0;
         drop_count <= '0;
      end else begin
         if (inc_pass) pass_count <= pass_count + 32'd1;
         if (inc_drop) drop_count <= drop_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_pkt_len_filter.sv
// tb/tb_pkt_len_filter.sv - self-checking bench for pkt_len_filter
module tb_pkt_len_filter;

   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int DW    = 64;
   localparam int CW    = 8;
   localparam int LW    = 12;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          in_wr = 1'b0;
   logic          in_rdy;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic          out_wr;
   logic          out_rdy = 1'b1;
   logic [LW-1:0] min_words = 12'd2;
   logic [LW-1:0] max_words = 12'd0;
   logic          counter_clear = 1'b0;
   logic [31:0]   pass_count;
   logic [31:0]   drop_count;

   always #5 clk = ~clk;

   pkt_len_filter #(
      .DATA_WIDTH(DW),
      .CTRL_WIDTH(CW),
      .ADDR_WIDTH(AW),
      .LEN_WIDTH(LW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_data(in_data),
      .in_ctrl(in_ctrl),
      .in_wr(in_wr),
      .in_rdy(in_rdy),
      .out_data(out_data),
      .out_ctrl(out_ctrl),
      .out_wr(out_wr),
      .out_rdy(out_rdy),
      .min_words(min_words),
      .max_words(max_words),
      .counter_clear(counter_clear),
      .pass_count(pass_count),
      .drop_count(drop_count)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // behavioural model state
   logic [CW+DW-1:0] cq[$];
   logic [CW+DW-1:0] pkt[$];
   bit               in_pkt = 0;
   bit               dropping = 0;
   bit               m_seen = 0;
   bit               body = 0;
   int               m_min = 0;
   int               m_max = 0;
   logic [31:0]      m_pass = 0;
   logic [31:0]      m_drop = 0;
   bit               rd_prev = 0;
   logic [CW+DW-1:0] rd_word = '0;
   logic [CW+DW-1:0] last_word = '0;

   bit arm_lat = 0;
   bit wait_out = 0;
   int acc_cyc = 0;
   int out_cyc = -100;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [CW+DW-1:0] act, input logic [CW+DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_word(input logic [CW-1:0] c, input logic [DW-1:0] d);
      int l;
      if (dropping) begin
         if (c == 0) m_seen = 1;
         else if (m_seen) begin
            m_drop++;
            dropping = 0;
         end
      end else if (!in_pkt) begin
         if (c != 0) begin
            pkt.delete();
            pkt.push_back({c, d});
            in_pkt = 1;
            body = 0;
            m_min = int'(min_words);
            m_max = int'(max_words);
         end
      end else if (body && c != 0) begin
         l = pkt.size() + 1;
         if (l >= m_min && (m_max == 0 || l <= m_max)) begin
            pkt.push_back({c, d});
            foreach (pkt[i]) cq.push_back(pkt[i]);
            m_pass++;
         end else begin
            m_drop++;
         end
         pkt.delete();
         in_pkt = 0;
      end else begin
         l = pkt.size() + 1;
         if ((m_max != 0 && l > m_max) || l == DEPTH - 1) begin
            dropping = 1;
            m_seen = (c == 0);
            pkt.delete();
            in_pkt = 0;
         end else begin
            pkt.push_back({c, d});
            if (c == 0) body = 1;
         end
      end
   endtask

   // compare process: checks every output each cycle, then advances the model
   always @(negedge clk) begin
      bit exp_rdy;
      if (reset) begin
         chk("rst_in_rdy", 72'(in_rdy), 72'(0));
         chk("rst_out_wr", 72'(out_wr), 72'(0));
         chk("rst_out_word", {out_ctrl, out_data}, 72'(0));
         chk("rst_pass", 72'(pass_count), 72'(0));
         chk("rst_drop", 72'(drop_count), 72'(0));
         cq.delete();
         pkt.delete();
         in_pkt = 0; dropping = 0; m_seen = 0; body = 0;
         m_pass = 0; m_drop = 0;
         rd_prev = 0; last_word = '0;
      end else begin
         exp_rdy = dropping || ((cq.size() + pkt.size()) != DEPTH - 1);
         chk("in_rdy", 72'(in_rdy), 72'(exp_rdy));
         chk("out_wr", 72'(out_wr), 72'(rd_prev));
         if (rd_prev) begin
            chk("out_word", {out_ctrl, out_data}, rd_word);
            last_word = rd_word;
            if (wait_out) begin
               out_cyc = cyc;
               wait_out = 0;
            end
         end else begin
            chk("out_hold", {out_ctrl, out_data}, last_word);
         end
         chk("pass_count", 72'(pass_count), 72'(m_pass));
         chk("drop_count", 72'(drop_count), 72'(m_drop));
         if (out_rdy && cq.size() > 0) begin
            rd_word = cq.pop_front();
            rd_prev = 1;
         end else begin
            rd_prev = 0;
         end
         if (in_wr && exp_rdy) begin
            if (arm_lat) begin
               acc_cyc = cyc;
               arm_lat = 0;
               wait_out = 1;
            end
            model_word(in_ctrl, in_data);
         end
         if (counter_clear) begin
            m_pass = 0;
            m_drop = 0;
         end
      end
   end

   task automatic put(input logic [CW-1:0] c, input logic [DW-1:0] d);
      int t;
      bit ok;
      in_ctrl = c;
      in_data = d;
      in_wr = 1'b1;
      t = 0;
      ok = 0;
      do begin
         @(negedge clk);
         ok = in_rdy;
         @(posedge clk);
         #1;
         t++;
      end while (!ok && t < 2000);
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL put_timeout: in_rdy stayed 0 for %0d cycles", t);
      end
      in_wr = 1'b0;
   endtask

   function automatic logic [CW-1:0] ctrl_of(input int i, input int n);
      if (i == 0) return 8'h01;
      if (i == n - 1) return 8'h80;
      return 8'h00;
   endfunction

   task automatic send_pkt(input int n, input int base);
      for (int i = 0; i < n; i++) put(ctrl_of(i, n), 64'(base * 256 + i));
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((cq.size() != 0 || rd_prev) && t < 1000) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (t >= 1000) begin
         fails++;
         $display("FAIL drain_timeout: %0d words still queued", cq.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // 5-word packet passes; first out_wr two cycles after EOP acceptance
      for (int i = 0; i < 4; i++) put(ctrl_of(i, 5), 64'(16'h0100 + i));
      arm_lat = 1;
      put(8'h80, 64'(16'h0104));
      wait_drain();
      chk("t1_latency", 72'(out_cyc - acc_cyc), 72'(2));
      chk("t1_pass", 72'(pass_count), 72'(1));
      chk("t1_drop", 72'(drop_count), 72'(0));

      // below minimum is dropped, exactly minimum passes
      min_words = 12'd8;
      send_pkt(5, 2);
      wait_drain();
      chk("t2_drop", 72'(drop_count), 72'(1));
      chk("t2_pass_before", 72'(pass_count), 72'(1));
      send_pkt(8, 3);
      wait_drain();
      chk("t2_pass", 72'(pass_count), 72'(2));

      // over maximum aborts early, exactly maximum passes
      min_words = 12'd2;
      max_words = 12'd6;
      send_pkt(10, 4);
      wait_drain();
      chk("t3_drop", 72'(drop_count), 72'(2));
      send_pkt(6, 5);
      wait_drain();
      chk("t3_pass", 72'(pass_count), 72'(3));

      // buffer-size limit: DEPTH-1 words is the longest packet that fits
      max_words = 12'd0;
      send_pkt(20, 6);
      wait_drain();
      chk("t4_drop20", 72'(drop_count), 72'(3));
      send_pkt(16, 7);
      wait_drain();
      chk("t4_drop16", 72'(drop_count), 72'(4));
      send_pkt(15, 8);
      wait_drain();
      chk("t4_pass15", 72'(pass_count), 72'(4));
      send_pkt(14, 9);
      wait_drain();
      chk("t4_pass14", 72'(pass_count), 72'(5));

      // limits are snapshotted at the header
      put(8'h01, 64'hA0);
      put(8'h00, 64'hA1);
      min_words = 12'd20;
      put(8'h00, 64'hA2);
      put(8'h00, 64'hA3);
      put(8'h80, 64'hA4);
      min_words = 12'd2;
      wait_drain();
      chk("cfg_latch_pass", 72'(pass_count), 72'(6));

      // backpressure: three 5-word packets fill the 15 usable slots
      out_rdy = 1'b0;
      fork
         for (int p = 0; p < 4; p++) send_pkt(5, 16 + p);
         begin
            repeat (30) @(posedge clk);
            #1;
            chk("t5_full_rdy", 72'(in_rdy), 72'(0));
            chk("t5_full_pass", 72'(pass_count), 72'(9));
            out_rdy = 1'b1;
         end
      join
      wait_drain();
      chk("t5_pass", 72'(pass_count), 72'(10));

      // reset mid-BODY with a committed packet waiting
      out_rdy = 1'b0;
      send_pkt(5, 32);
      put(8'h01, 64'hB0);
      put(8'h00, 64'hB1);
      put(8'h00, 64'hB2);
      reset = 1'b1;
      #1;
      chk("t6_rst_pass", 72'(pass_count), 72'(0));
      chk("t6_rst_rdy", 72'(in_rdy), 72'(0));
      chk("t6_rst_out", {out_ctrl, out_data}, 72'(0));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      out_rdy = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      send_pkt(5, 33);
      wait_drain();
      chk("t6_pass", 72'(pass_count), 72'(1));

      // counter_clear coincident with a pass wins
      for (int i = 0; i < 4; i++) put(ctrl_of(i, 5), 64'(16'h2200 + i));
      counter_clear = 1'b1;
      put(8'h80, 64'h2204);
      counter_clear = 1'b0;
      chk("t7_clear_pass", 72'(pass_count), 72'(0));
      chk("t7_clear_drop", 72'(drop_count), 72'(0));
      wait_drain();
      send_pkt(5, 35);
      wait_drain();
      chk("t7_pass_after", 72'(pass_count), 72'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
